// File: rtl/simon_pkg.sv
// Purpose: shared types and helpers for the button-to-game-FSM interface.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
// Contents: evt_state_t (event FSM states), colour_t (2-bit colour index),
//           is_onehot(), encode_onehot() (also used by the game FSM side).
package simon_pkg;

  localparam int unsigned NUM_BTN = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,  // no event pending, buttons released
    ST_PEND_HELD = 2'd1,  // event pending, button still down
    ST_PEND_REL  = 2'd2,  // event pending, all buttons released
    ST_WAIT_REL  = 2'd3   // event consumed or rejected, waiting for release
  } evt_state_t;

  typedef logic [1:0] colour_t;

  // v & (v-1) clears the lowest set bit; zero afterwards means at most one bit.
  function automatic logic is_onehot(input logic [NUM_BTN-1:0] v);
    return (v != '0) && ((v & (v - 4'd1)) == '0);
  endfunction

  // Only meaningful for one-hot input; highest set bit wins otherwise.
  function automatic colour_t encode_onehot(input logic [NUM_BTN-1:0] v);
    colour_t idx;
    idx = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (v[i]) idx = colour_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/btn_debounce_sync.sv
// Purpose: synchronise and debounce a 4-bit raw button vector.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES edges from first sampling edge to o_stable.
// Backpressure: none; free-running.
// Ports: clk, rst_n (async active-low), i_btn (raw async levels),
//        o_stable (debounced vector).
module btn_debounce_sync
  import simon_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] i_btn,
  output logic [NUM_BTN-1:0] o_stable
);

  localparam logic [CNT_W-1:0] CNT_COMMIT = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic [NUM_BTN-1:0] r_sync [SYNC_STAGES];
  logic [NUM_BTN-1:0] r_prev;
  logic [NUM_BTN-1:0] r_stable;
  logic [CNT_W-1:0]   r_cnt;

  logic [NUM_BTN-1:0] w_sync_btn;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_commit;

  assign w_sync_btn = r_sync[SYNC_STAGES-1];

  // Commit on the edge where the counter arrives at DEBOUNCE_CYCLES-1, so the
  // synchronised value has been seen unchanged for DEBOUNCE_CYCLES cycles.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_sync_btn != r_prev) begin
      w_cnt_nxt = '0;
    end else if (r_cnt != CNT_MAX) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
    w_commit = (w_cnt_nxt == CNT_COMMIT) && (w_sync_btn != r_stable);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_prev   <= '0;
      r_cnt    <= '0;
      r_stable <= '0;
    end else begin
      r_sync[0] <= i_btn;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= w_sync_btn;
      r_cnt  <= w_cnt_nxt;
      if (w_commit) r_stable <= w_sync_btn;
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/button_event_encoder.sv
// Purpose: turn bouncing push-buttons into held single press events {valid, index}.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES + 1 edges from first sampling edge to evt_valid.
// Backpressure: event held until evt_ready; presses arriving while pending are dropped.
// Ports: clk, reset_n (async active-low), btn[3:0] raw levels, evt_valid/evt_val/
//        evt_ready handshake, stable_btn debounced echo, multi_err and drop_pulse
//        one-cycle status pulses.
module button_event_encoder
  import simon_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_BTN-1:0] btn,
  output logic               evt_valid,
  output colour_t            evt_val,
  input  logic               evt_ready,
  output logic [NUM_BTN-1:0] stable_btn,
  output logic               multi_err,
  output logic               drop_pulse
);

  // Reset asserts asynchronously but releases on a clock edge, so no flop
  // sees reset removal close to its active edge.
  logic r_rst_meta;
  logic r_rst_sync;
  logic w_rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end

  assign w_rst_n = r_rst_sync;

  logic [NUM_BTN-1:0] w_stable;

  btn_debounce_sync #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_debounce (
    .clk      (clk),
    .rst_n    (w_rst_n),
    .i_btn    (btn),
    .o_stable (w_stable)
  );

  evt_state_t r_state;
  logic       r_valid;
  colour_t    r_val;
  logic       r_multi;
  logic       r_drop;

  evt_state_t w_state_nxt;
  logic       w_valid_nxt;
  colour_t    w_val_nxt;
  logic       w_multi_nxt;
  logic       w_drop_nxt;
  logic       w_accept;
  logic       w_zero;
  logic       w_onehot;

  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    w_val_nxt   = r_val;
    w_multi_nxt = 1'b0;
    w_drop_nxt  = 1'b0;
    w_accept    = r_valid & evt_ready;
    w_zero      = (w_stable == '0);
    w_onehot    = is_onehot(w_stable);

    case (r_state)
      ST_IDLE: begin
        if (w_onehot) begin
          w_state_nxt = ST_PEND_HELD;
          w_valid_nxt = 1'b1;
          w_val_nxt   = encode_onehot(w_stable);
        end else if (!w_zero) begin
          w_multi_nxt = 1'b1;
          w_state_nxt = ST_WAIT_REL;
        end
      end
      ST_PEND_HELD: begin
        if (w_accept) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = w_zero ? ST_IDLE : ST_WAIT_REL;
        end else if (w_zero) begin
          w_state_nxt = ST_PEND_REL;
        end
      end
      ST_PEND_REL: begin
        // A press seen here was not seen from IDLE, so it is never reported,
        // even when it coincides with the accept of the pending event.
        if (w_accept) begin
          w_valid_nxt = 1'b0;
          if (w_zero) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_WAIT_REL;
            w_drop_nxt  = w_onehot;
          end
        end else if (!w_zero) begin
          w_state_nxt = ST_PEND_HELD;
          w_drop_nxt  = w_onehot;
        end
      end
      ST_WAIT_REL: begin
        if (w_zero) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_val   <= '0;
      r_multi <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_valid_nxt;
      r_val   <= w_val_nxt;
      r_multi <= w_multi_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  assign evt_valid  = r_valid;
  assign evt_val    = r_val;
  assign stable_btn = w_stable;
  assign multi_err  = r_multi;
  assign drop_pulse = r_drop;

endmodule

// File: tb/tb_button_event_encoder.sv
// Purpose: scoreboard bench for button_event_encoder with directed button vectors.
// Latency: n/a.
// Backpressure: evt_ready driven directly by the stimulus process.
module tb_button_event_encoder;
  import simon_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] btn;
  logic       evt_valid;
  colour_t    evt_val;
  logic       evt_ready;
  logic [3:0] stable_btn;
  logic       multi_err;
  logic       drop_pulse;

  button_event_encoder #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (4),
    .SYNC_STAGES     (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn        (btn),
    .evt_valid  (evt_valid),
    .evt_val    (evt_val),
    .evt_ready  (evt_ready),
    .stable_btn (stable_btn),
    .multi_err  (multi_err),
    .drop_pulse (drop_pulse)
  );

  always #5 clk = ~clk;

  int checks      = 0;
  int errors      = 0;
  int ev_count    = 0;
  int multi_count = 0;
  int drop_count  = 0;
  int exp_q[$];

  logic    prev_valid = 1'b0;
  logic    prev_ready = 1'b0;
  colour_t prev_val   = '0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: on each falling edge, a visible valid&ready is a transfer that
  // completes on the next rising edge; compare it against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_valid = 1'b0;
        prev_ready = 1'b0;
      end else begin
        if (evt_valid && prev_valid && !prev_ready)
          check("evt_val_held", int'(evt_val), int'(prev_val));
        if (evt_valid && evt_ready) begin
          check("event_was_expected", (exp_q.size() > 0) ? 1 : 0, 1);
          if (exp_q.size() > 0) check("evt_val", int'(evt_val), exp_q.pop_front());
          ev_count++;
        end
        if (multi_err)  multi_count++;
        if (drop_pulse) drop_count++;
        prev_valid = evt_valid;
        prev_ready = evt_ready;
        prev_val   = evt_val;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_events(input int target, input string name);
    for (int k = 0; k < 60 && ev_count < target; k++) tick(1);
    check(name, ev_count, target);
  endtask

  initial begin
    int n_ev;
    int lat;
    n_ev      = 0;
    reset_n   = 1'b0;
    btn       = 4'b0100;
    evt_ready = 1'b1;

    // Reset with a button held
    tick(3);
    @(negedge clk);
    check("rst_evt_valid",  int'(evt_valid),  0);
    check("rst_evt_val",    int'(evt_val),    0);
    check("rst_stable_btn", int'(stable_btn), 0);
    check("rst_multi_err",  int'(multi_err),  0);
    check("rst_drop_pulse", int'(drop_pulse), 0);
    exp_q.push_back(2);
    n_ev++;
    reset_n = 1'b1;
    wait_events(n_ev, "event_after_reset_release");
    btn = 4'b0000;
    tick(12);

    // Clean press, latency 2 + 4 + 1 edges
    exp_q.push_back(1);
    n_ev++;
    btn = 4'b0010;
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (evt_valid) begin
        lat = k;
        break;
      end
    end
    check("press_latency", lat, 7);
    check("press_evt_val", int'(evt_val), 1);
    @(negedge clk);
    check("press_one_cycle_valid", int'(evt_valid), 0);
    tick(12);
    btn = 4'b0000;
    tick(12);
    check("single_event_per_press", ev_count, n_ev);

    // Bounce: 2-cycle toggles never pass the 4-cycle filter
    for (int s = 0; s < 6; s++) begin
      btn = (s % 2 == 0) ? 4'b1000 : 4'b0000;
      tick(2);
    end
    check("bounce_no_event", ev_count, n_ev);
    check("bounce_stable_zero", int'(stable_btn), 0);
    exp_q.push_back(3);
    n_ev++;
    btn = 4'b1000;
    wait_events(n_ev, "bounce_settled_event");
    tick(5);
    check("bounce_single_event", ev_count, n_ev);
    btn = 4'b0000;
    tick(12);

    // Backpressure: event held across release, later press dropped
    evt_ready = 1'b0;
    exp_q.push_back(0);
    n_ev++;
    btn = 4'b0001;
    tick(10);
    check("bp_valid_pending", int'(evt_valid), 1);
    check("bp_val_pending",   int'(evt_val),   0);
    btn = 4'b0000;
    tick(10);
    check("bp_valid_after_release", int'(evt_valid),  1);
    check("bp_val_after_release",   int'(evt_val),    0);
    check("bp_stable_released",     int'(stable_btn), 0);
    btn = 4'b0100;
    tick(10);
    check("bp_drop_count", drop_count, 1);
    check("bp_val_kept",   int'(evt_val),   0);
    check("bp_valid_kept", int'(evt_valid), 1);
    evt_ready = 1'b1;
    tick(1);
    @(negedge clk);
    check("bp_valid_drops_after_accept", int'(evt_valid), 0);
    check("bp_one_transfer", ev_count, n_ev);
    btn = 4'b0000;
    tick(12);

    // Multi-hot press
    btn = 4'b0011;
    tick(12);
    check("multi_err_count", multi_count, 1);
    check("multi_no_valid",  int'(evt_valid), 0);
    check("multi_no_event",  ev_count, n_ev);
    btn = 4'b0000;
    tick(12);
    exp_q.push_back(0);
    n_ev++;
    btn = 4'b0001;
    wait_events(n_ev, "post_multi_event");
    btn = 4'b0000;
    tick(12);

    // Reset with an event pending
    evt_ready = 1'b0;
    btn = 4'b0010;
    tick(10);
    check("pre_reset_pending", int'(evt_valid), 1);
    btn = 4'b0000;
    tick(10);
    reset_n = 1'b0;
    #1;
    check("async_reset_valid", int'(evt_valid), 0);
    tick(1);
    reset_n   = 1'b1;
    evt_ready = 1'b1;
    tick(20);
    check("no_stale_valid", int'(evt_valid), 0);
    check("no_stale_event", ev_count, n_ev);
    exp_q.push_back(1);
    n_ev++;
    btn = 4'b0010;
    wait_events(n_ev, "fresh_press_after_reset");
    btn = 4'b0000;
    tick(12);

    check("scoreboard_empty", exp_q.size(), 0);
    check("total_drops", drop_count, 1);
    check("total_multi", multi_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
